// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, NOP encoding,
// default reset PC and the next-PC source encoding.
package fetch_pkg;

    localparam int          IF_ID_BUS_W      = 64;
    localparam int          JBR_BUS_W        = 33;
    localparam int          EXC_BUS_W        = 33;
    localparam logic [31:0] INST_NOP         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        PC_SRC_SEQ  = 2'd0,
        PC_SRC_JBR  = 2'd1,
        PC_SRC_PEND = 2'd2,
        PC_SRC_EXC  = 2'd3
    } pc_src_e;

    // Sequential successor; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: exception, then pending redirect, then taken jump/branch,
// then PC+4.
module fetch_pc_sel
    import fetch_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic        exc_valid_i,
    input  logic [31:0] exc_pc_i,
    input  logic        pend_valid_i,
    input  logic [31:0] pend_target_i,
    input  logic        jbr_taken_i,
    input  logic [31:0] jbr_target_i,
    output logic [31:0] next_pc_o,
    output pc_src_e     src_o
);

    // Priority selection of the next PC and the source it came from.
    always_comb begin
        next_pc_o = pc_plus4(pc_i);
        src_o     = PC_SRC_SEQ;
        if (exc_valid_i) begin
            next_pc_o = exc_pc_i;
            src_o     = PC_SRC_EXC;
        end else if (pend_valid_i) begin
            next_pc_o = pend_target_i;
            src_o     = PC_SRC_PEND;
        end else if (jbr_taken_i) begin
            next_pc_o = jbr_target_i;
            src_o     = PC_SRC_JBR;
        end else begin
            next_pc_o = pc_plus4(pc_i);
            src_o     = PC_SRC_SEQ;
        end
    end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: PC register, fetch-complete flag and pending redirect.
// Optional FETCH_ADEF_EN adds the misaligned-fetch flag if_adef and NOP substitution.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   IF_valid,
    input  logic                   next_fetch,
    input  logic [31:0]            inst,
    input  logic [JBR_BUS_W-1:0]   jbr_bus,
    input  logic [EXC_BUS_W-1:0]   exc_bus,
    output logic [31:0]            inst_addr,
    output logic                   IF_over,
    output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
    output logic [31:0]            IF_pc
`ifdef FETCH_ADEF_EN
    ,
    output logic                   if_adef
`endif
);

    logic [31:0] pc_q, pc_d;
    logic        if_over_q, if_over_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        jbr_taken_s;
    logic [31:0] jbr_target_s;
    logic        exc_valid_s;
    logic [31:0] exc_pc_s;
    logic [31:0] next_pc_s;
    pc_src_e     src_s;
    logic        pc_load_s;
    logic [31:0] inst_field_s;

    assign jbr_taken_s  = jbr_bus[32];
    assign jbr_target_s = jbr_bus[31:0];
    assign exc_valid_s  = exc_bus[32];
    assign exc_pc_s     = exc_bus[31:0];

    fetch_pc_sel u_pc_sel (
        .pc_i          (pc_q),
        .exc_valid_i   (exc_valid_s),
        .exc_pc_i      (exc_pc_s),
        .pend_valid_i  (pend_valid_q),
        .pend_target_i (pend_target_q),
        .jbr_taken_i   (jbr_taken_s),
        .jbr_target_i  (jbr_target_s),
        .next_pc_o     (next_pc_s),
        .src_o         (src_s)
    );

    // Exceptions force a PC load even when the pipeline is stalled.
    assign pc_load_s = exc_valid_s | next_fetch;

    // Next-state for PC, fetch-complete flag and pending redirect.
    always_comb begin
        pc_d          = pc_q;
        if_over_d     = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;

        if (pc_load_s) begin
            pc_d      = next_pc_s;
            if_over_d = 1'b0;
        end else begin
            pc_d      = pc_q;
            if_over_d = IF_valid;
        end

        // A redirect seen while stalled is remembered until the PC can move.
        if (exc_valid_s) begin
            pend_valid_d = 1'b0;
        end else if (jbr_taken_s && !next_fetch) begin
            pend_valid_d  = 1'b1;
            pend_target_d = jbr_target_s;
        end else if (next_fetch && (src_s == PC_SRC_PEND)) begin
            pend_valid_d = 1'b0;
        end else begin
            pend_valid_d = pend_valid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_over_q     <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            if_over_q     <= if_over_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef FETCH_ADEF_EN
    logic adef_s;
    assign adef_s       = if_over_q & (pc_q[1:0] != 2'b00);
    assign if_adef      = adef_s;
    assign inst_field_s = adef_s ? INST_NOP : inst;
`else
    assign inst_field_s = inst;
`endif

    assign inst_addr = pc_q;
    assign IF_pc     = pc_q;
    assign IF_over   = if_over_q;
    assign IF_ID_bus = {pc_q, inst_field_s};

endmodule
